// File: rtl/tsv_link_framer.sv
// tsv_link_framer: byte-stream to 9-bit DPS symbol framer (SOF/payload/[XOR chk]/EOF, IDLE/FILL fillers)
// Ports: clock, reset (async, active-high); in_valid/in_ready/in_data/in_last byte input;
// link_en gates symbol progress; sym_out registered symbol (0..259); frame_count completed frames.
// Define FRAMER_CRC_EN to append an XOR checksum byte before each EOF.
`ifndef DBLEN11
`define DBLEN11 9
`endif
module tsv_link_framer #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LEN = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  input  logic                link_en,
  output logic [`DBLEN11-1:0] sym_out,
  output logic [15:0]         frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [`DBLEN11-1:0] IDLE = 256, SOF = 257, EOF = 258, FILL = 259;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  typedef logic [AW:0] cnt_t;
`ifdef FRAMER_CRC_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK, S_EOF} state_t;
  logic [7:0] chk;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOF} state_t;
`endif
  state_t state;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  cnt_t cnt;
  logic [7:0] bcnt, bcnt_nx;
  logic [8:0] head;
  logic empty, go, push, pop;
  assign empty = cnt == '0;
  assign in_ready = cnt != cnt_t'(FIFO_DEPTH);
  assign push = in_valid && in_ready;
  assign go = link_en && !empty;
  assign pop = state == S_DATA && go;
  assign head = mem[rp];
  assign bcnt_nx = bcnt + 8'd1;
  always_ff @(posedge clock)
    if (push) mem[wp] <= {in_last, in_data};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      sym_out <= IDLE;
      frame_count <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      bcnt <= '0;
`ifdef FRAMER_CRC_EN
      chk <= '0;
`endif
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + cnt_t'(push) - cnt_t'(pop);
      case (state)
        S_IDLE:
          if (go) begin
            sym_out <= SOF;
            bcnt <= '0;
`ifdef FRAMER_CRC_EN
            chk <= '0;
`endif
            state <= S_DATA;
          end else sym_out <= IDLE;
        S_DATA:
          if (pop) begin
            sym_out <= {1'b0, head[7:0]};
            bcnt <= bcnt_nx;
`ifdef FRAMER_CRC_EN
            chk <= chk ^ head[7:0];
            if (head[8] || bcnt_nx == MAX_B) state <= S_CHK;
`else
            if (head[8] || bcnt_nx == MAX_B) state <= S_EOF;
`endif
          end else sym_out <= FILL;
`ifdef FRAMER_CRC_EN
        S_CHK:
          if (link_en) begin
            sym_out <= {1'b0, chk};
            state <= S_EOF;
          end else sym_out <= FILL;
`endif
        S_EOF:
          if (link_en) begin
            sym_out <= EOF;
            frame_count <= frame_count + 16'd1;
            state <= S_IDLE;
          end else sym_out <= FILL;
        default: begin
          state <= S_IDLE;
          sym_out <= IDLE;
        end
      endcase
    end
endmodule
